recompose_ctrl: RTL and testbench
=================================

Name: recompose_ctrl

Overview:
- Inverse of the ML-DSA decompose stage. Streams polynomials from memory and writes r = (r1·2γ2 + r0) mod q back to memory, 4 coefficients per word.
- r0 comes from the main memory in mod-q representation; r1 comes from a parallel hint/high-bits buffer at the same word index.
- Sits beside the decompose block under the ML-DSA top-level sequencer, using the same read/write FSM style.

Parameters:
- REG_SIZE, 24, coefficient container width (q is 23 bits).
- MEM_ADDR_W, 15, memory address width.
- COEFF_PER_WORD, 4, coefficients per memory word.
- WORDS_PER_POLY, 64, words per polynomial (N=256 / 4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- zeroize  in  1  synchronous clear; same effect as rst.
- recomp_enable  in  1  start pulse; sampled only in IDLE.
- num_poly  in  4  polynomials to process (0..15).
- src_base_addr  in  MEM_ADDR_W  r0 read base.
- dest_base_addr  in  MEM_ADDR_W  r write base.
- mem_rd_en  out  1  read strobe, r0 memory and r1 buffer.
- mem_rd_addr  out  MEM_ADDR_W  read word address.
- r1_rd_addr  out  MEM_ADDR_W-2  r1 buffer word index.
- mem_rd_data  in  4*REG_SIZE  r0 word; valid 1 cycle after mem_rd_en.
- r1_rd_data  in  16  four 4-bit r1 values; valid 1 cycle after mem_rd_en.
- mem_wr_en  out  1  write strobe.
- mem_wr_addr  out  MEM_ADDR_W  write address.
- mem_wr_data  out  4*REG_SIZE  recomposed word.
- recomp_busy  out  1  high from start until done.
- recomp_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: all outputs 0. Both FSMs in IDLE; all counters 0.
- Constants: q=8380417, γ2=(q-1)/32=261888, 2γ2=523776. Lane i occupies bits [i*REG_SIZE +: REG_SIZE].
- Read FSM, RCMP_RD_IDLE → RCMP_RD_MEM:
  - Transition on recomp_enable when num_poly≠0. Latch the base addresses and total = num_poly·64.
  - In MEM: mem_rd_en=1 every cycle. mem_rd_addr = src_base + cnt; r1_rd_addr = cnt.
  - Return to IDLE after issuing the total-th read.
- num_poly=0: no memory accesses. recomp_done pulses on the cycle after the start pulse; busy stays low.
- Pipeline:
  - Stage 1: mem_rd_en delayed one cycle becomes data_valid.
  - Stage 2: per lane, s = r1·523776 + r0 (25 bits). Output s−q if s≥q, else s. Registered into mem_wr_data.
- Write FSM, RCMP_WR_IDLE → RCMP_WR_MEM:
  - Enter on the first data_valid.
  - mem_wr_en asserts 2 cycles after the corresponding mem_rd_en. mem_wr_addr = dest_base + write count.
  - Return to IDLE after the total-th write.
- recomp_done pulses the cycle after the last write; busy drops the same cycle.
- Latency for one polynomial: start → done = 1 + 64 + 2 cycles.
- r0 inputs ≥ q are not validated unless the optional feature is enabled; the output is still reduced once.
- recomp_enable while busy: ignored, no restart.
- rst or zeroize mid-operation: next cycle both FSMs are IDLE, counters and outputs 0, and no done pulse. Data returning in flight is discarded.
- src and dest regions may alias; the write lags the read of the same word by 2 cycles, so this is safe.

Optional Feature:
- Macro: RECOMPOSE_RANGE_CHECK_EN.
- Enabled:
  - Extra output port recomp_err (1 bit).
  - Set sticky in stage 2 if any valid lane has q−γ2 > r0 > γ2, i.e. 261888 < r0 < 8118529.
  - Cleared on rst, zeroize or a new accepted start.
  - Data is still written unchanged.
- Disabled: port absent, no check logic.

Decomposition:
- recompose_defines_pkg holds:
  - typedef enum logic {RCMP_RD_IDLE, RCMP_RD_MEM} rcmp_read_state_e.
  - typedef enum logic {RCMP_WR_IDLE, RCMP_WR_MEM} rcmp_write_state_e.
  - Localparams RCMP_Q, RCMP_GAMMA2, RCMP_2GAMMA2, RCMP_WORDS_PER_POLY.
- Sub-module recompose_unit: combinational, one lane; inputs r1[3:0] and r0[REG_SIZE-1:0], outputs reduced r and range flag. Instantiated COEFF_PER_WORD times under generate.

Test Plan:
- Values, one polynomial; all lanes equal, output identical in every lane:
  - r1=0, r0=0 → 0.
  - r1=15, r0=261888 → 8118528.
  - r1=1, r0=8380416 → 523775.
  - r1=15, r0=8380416 → 7856639.
- Timing: start at cycle 0, num_poly=2, src=0x100, dest=0x400 → reads 0x100..0x17F on cycles 1..128. Writes 0x400..0x47F on cycles 3..130. done on cycle 131.
- num_poly=0 → no rd/wr strobes; done on cycle 1; busy stays 0.
- recomp_enable re-pulsed at cycle 20 of a run → ignored; addresses unchanged; single done pulse.
- zeroize asserted at cycle 30 → cycle 31: FSMs IDLE, outputs 0, no writes afterwards, no done. A fresh start then runs normally.
- RECOMPOSE_RANGE_CHECK_EN: lane r0=261889 → recomp_err=1, sticky, data written. Same run with r0=8118529 → err stays 0.

Source files
------------

// File: rtl/recompose_defines_pkg.sv
// Shared types and constants for the ML-DSA recompose controller.
package recompose_defines_pkg;

  typedef enum logic {RCMP_RD_IDLE, RCMP_RD_MEM} rcmp_read_state_e;
  typedef enum logic {RCMP_WR_IDLE, RCMP_WR_MEM} rcmp_write_state_e;

  localparam int unsigned RCMP_Q              = 32'd8380417;
  localparam int unsigned RCMP_GAMMA2         = (RCMP_Q - 1) / 32;
  localparam int unsigned RCMP_2GAMMA2        = 2 * RCMP_GAMMA2;
  localparam int unsigned RCMP_WORDS_PER_POLY = 64;

endpackage

// File: rtl/recompose_unit.sv
// One-lane recompose: r = (r1*2*gamma2 + r0) with a single conditional
// subtraction of q. Also flags r0 values inside the open band (gamma2, q-gamma2).
module recompose_unit
  import recompose_defines_pkg::*;
#(
  parameter int REG_SIZE = 24
) (
  input  logic [3:0]          r1,
  input  logic [REG_SIZE-1:0] r0,
  output logic [REG_SIZE-1:0] r,
  output logic                range_flag
);

  localparam int SW = REG_SIZE + 1;

  logic [SW-1:0] s;

  // Sum, single reduction and range flag
  always_comb begin
    s = SW'(r1) * SW'(RCMP_2GAMMA2) + SW'(r0);
    if (s >= SW'(RCMP_Q)) r = REG_SIZE'(s - SW'(RCMP_Q));
    else                  r = REG_SIZE'(s);
    range_flag = (r0 > REG_SIZE'(RCMP_GAMMA2)) &&
                 (r0 < REG_SIZE'(RCMP_Q - RCMP_GAMMA2));
  end

endmodule

// File: rtl/recompose_ctrl.sv
// Recompose controller: streams r0 words and r1 hints from memory, writes
// (r1*2*gamma2 + r0) mod q back, 4 coefficients per word.
// Optional macro RECOMPOSE_RANGE_CHECK_EN adds the sticky recomp_err output.
module recompose_ctrl
  import recompose_defines_pkg::*;
#(
  parameter int REG_SIZE       = 24,
  parameter int MEM_ADDR_W     = 15,
  parameter int COEFF_PER_WORD = 4,
  parameter int WORDS_PER_POLY = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               zeroize,
  input  logic                               recomp_enable,
  input  logic [3:0]                         num_poly,
  input  logic [MEM_ADDR_W-1:0]              src_base_addr,
  input  logic [MEM_ADDR_W-1:0]              dest_base_addr,
  output logic                               mem_rd_en,
  output logic [MEM_ADDR_W-1:0]              mem_rd_addr,
  output logic [MEM_ADDR_W-3:0]              r1_rd_addr,
  input  logic [COEFF_PER_WORD*REG_SIZE-1:0] mem_rd_data,
  input  logic [15:0]                        r1_rd_data,
  output logic                               mem_wr_en,
  output logic [MEM_ADDR_W-1:0]              mem_wr_addr,
  output logic [COEFF_PER_WORD*REG_SIZE-1:0] mem_wr_data,
  output logic                               recomp_busy,
  output logic                               recomp_done
`ifdef RECOMPOSE_RANGE_CHECK_EN
  ,
  output logic                               recomp_err
`endif
);

  localparam int CNT_W = $clog2(15 * WORDS_PER_POLY + 1);

  rcmp_read_state_e  rd_state, rd_state_next;
  rcmp_write_state_e wr_state, wr_state_next;

  logic [CNT_W-1:0]      total;
  logic [CNT_W-1:0]      rd_cnt;
  logic [CNT_W-1:0]      wr_cnt;
  logic [MEM_ADDR_W-1:0] src_q;
  logic [MEM_ADDR_W-1:0] dest_q;
  logic                  data_valid;
  logic                  wr_last;
  logic                  wr_last_q;
  logic                  accept;

  logic [COEFF_PER_WORD*REG_SIZE-1:0] lane_r;
  logic [COEFF_PER_WORD-1:0]          lane_flag;

  assign accept  = recomp_enable && (rd_state == RCMP_RD_IDLE) && !recomp_busy;
  assign wr_last = data_valid && (wr_cnt == total - CNT_W'(1));

  for (genvar i = 0; i < COEFF_PER_WORD; i++) begin : g_lane
    recompose_unit #(.REG_SIZE(REG_SIZE)) u_unit (
      .r1         (r1_rd_data[i*4 +: 4]),
      .r0         (mem_rd_data[i*REG_SIZE +: REG_SIZE]),
      .r          (lane_r[i*REG_SIZE +: REG_SIZE]),
      .range_flag (lane_flag[i])
    );
  end

  // Read FSM next state and read-port outputs
  always_comb begin
    rd_state_next = rd_state;
    mem_rd_en     = 1'b0;
    mem_rd_addr   = '0;
    r1_rd_addr    = '0;
    case (rd_state)
      RCMP_RD_IDLE: begin
        if (accept && (num_poly != '0)) rd_state_next = RCMP_RD_MEM;
      end
      RCMP_RD_MEM: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = src_q + MEM_ADDR_W'(rd_cnt);
        r1_rd_addr  = (MEM_ADDR_W-2)'(rd_cnt);
        if (rd_cnt == total - CNT_W'(1)) rd_state_next = RCMP_RD_IDLE;
      end
      default: rd_state_next = RCMP_RD_IDLE;
    endcase
  end

  // Write FSM next state: enters on first valid word, leaves on the last
  always_comb begin
    wr_state_next = wr_state;
    case (wr_state)
      RCMP_WR_IDLE: if (data_valid) wr_state_next = RCMP_WR_MEM;
      RCMP_WR_MEM:  if (wr_last)    wr_state_next = RCMP_WR_IDLE;
      default:      wr_state_next = RCMP_WR_IDLE;
    endcase
  end

  // Control state: FSMs, counters, latched bases, busy/done
  always_ff @(posedge clk) begin
    if (rst || zeroize) begin
      rd_state    <= RCMP_RD_IDLE;
      wr_state    <= RCMP_WR_IDLE;
      total       <= '0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      src_q       <= '0;
      dest_q      <= '0;
      wr_last_q   <= 1'b0;
      recomp_busy <= 1'b0;
      recomp_done <= 1'b0;
    end else begin
      rd_state  <= rd_state_next;
      wr_state  <= wr_state_next;
      wr_last_q <= wr_last;
      if (accept) begin
        src_q  <= src_base_addr;
        dest_q <= dest_base_addr;
        total  <= CNT_W'(num_poly) * CNT_W'(WORDS_PER_POLY);
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (rd_state == RCMP_RD_MEM)
          rd_cnt <= (rd_state_next == RCMP_RD_IDLE) ? '0 : rd_cnt + CNT_W'(1);
        if (data_valid)
          wr_cnt <= wr_last ? '0 : wr_cnt + CNT_W'(1);
      end
      // An empty job completes immediately without ever raising busy
      recomp_done <= (accept && (num_poly == '0)) || wr_last_q;
      if (accept && (num_poly != '0)) recomp_busy <= 1'b1;
      else if (wr_last_q)             recomp_busy <= 1'b0;
    end
  end

  // Datapath pipeline: read-valid delay, then registered recomposed write
  always_ff @(posedge clk) begin
    if (rst || zeroize) begin
      data_valid  <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      data_valid  <= mem_rd_en;
      mem_wr_en   <= data_valid;
      mem_wr_addr <= data_valid ? dest_q + MEM_ADDR_W'(wr_cnt) : '0;
      mem_wr_data <= data_valid ? lane_r : '0;
    end
  end

`ifdef RECOMPOSE_RANGE_CHECK_EN
  // Sticky range error, cleared by a newly accepted start
  always_ff @(posedge clk) begin
    if (rst || zeroize)                 recomp_err <= 1'b0;
    else if (accept)                    recomp_err <= 1'b0;
    else if (data_valid && |lane_flag)  recomp_err <= 1'b1;
  end
`else
  logic unused_lane_flag;
  assign unused_lane_flag = ^lane_flag;
`endif

endmodule

// File: tb/tb_recompose_ctrl.sv
// Directed self-checking bench for recompose_ctrl.
module tb_recompose_ctrl;

  logic        clk;
  logic        rst;
  logic        zeroize;
  logic        recomp_enable;
  logic [3:0]  num_poly;
  logic [14:0] src_base_addr;
  logic [14:0] dest_base_addr;
  logic        mem_rd_en;
  logic [14:0] mem_rd_addr;
  logic [12:0] r1_rd_addr;
  logic [95:0] mem_rd_data;
  logic [15:0] r1_rd_data;
  logic        mem_wr_en;
  logic [14:0] mem_wr_addr;
  logic [95:0] mem_wr_data;
  logic        recomp_busy;
  logic        recomp_done;
`ifdef RECOMPOSE_RANGE_CHECK_EN
  logic        recomp_err;
`endif

  int errors = 0;
  int checks = 0;

  logic [23:0] r0v;
  logic [3:0]  r1v;
  logic [46:0] obs;
  logic [46:0] ev;

  recompose_ctrl #(
    .REG_SIZE(24), .MEM_ADDR_W(15), .COEFF_PER_WORD(4), .WORDS_PER_POLY(64)
  ) dut (
    .clk(clk), .rst(rst), .zeroize(zeroize), .recomp_enable(recomp_enable),
    .num_poly(num_poly), .src_base_addr(src_base_addr), .dest_base_addr(dest_base_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .r1_rd_addr(r1_rd_addr),
    .mem_rd_data(mem_rd_data), .r1_rd_data(r1_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .recomp_busy(recomp_busy), .recomp_done(recomp_done)
`ifdef RECOMPOSE_RANGE_CHECK_EN
    , .recomp_err(recomp_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: one-cycle read latency, every lane holds the current fill value
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= {4{r0v}};
      r1_rd_data  <= {4{r1v}};
    end
  end

  // Expected port vector at cycle c after a start pulse at cycle 0
  function automatic logic [46:0] exp_vec(input int c, input int np,
                                          input logic [14:0] src, input logic [14:0] dest);
    int total;
    logic rd, wr, busy, done;
    logic [14:0] rda, wra;
    logic [12:0] r1a;
    total = np * 64;
    rd   = (c >= 1) && (c <= total);
    wr   = (c >= 3) && (c <= total + 2);
    busy = (total != 0) && (c >= 1) && (c <= total + 2);
    done = (total == 0) ? (c == 1) : (c == total + 3);
    rda  = rd ? src + 15'(c - 1) : 15'd0;
    r1a  = rd ? 13'(c - 1) : 13'd0;
    wra  = wr ? dest + 15'(c - 3) : 15'd0;
    return {rd, rda, r1a, wr, wra, busy, done};
  endfunction

  task automatic start_run(input int np, input logic [14:0] src, input logic [14:0] dest);
    @(negedge clk);
    num_poly       = 4'(np);
    src_base_addr  = src;
    dest_base_addr = dest;
    recomp_enable  = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; zeroize = 1'b0; recomp_enable = 1'b0; num_poly = '0;
    src_base_addr = '0; dest_base_addr = '0; r0v = '0; r1v = '0;
    repeat (3) @(negedge clk);
    obs = {mem_rd_en, mem_rd_addr, r1_rd_addr, mem_wr_en, mem_wr_addr, recomp_busy, recomp_done};
    checks++;
    if (obs !== 47'd0) begin
      errors++; $display("FAIL reset_ports got %h want 0", obs);
    end
    checks++;
    if (mem_wr_data !== 96'd0) begin
      errors++; $display("FAIL reset_wr_data got %h want 0", mem_wr_data);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_values();
    logic [23:0] r0t [4] = '{24'd0, 24'd261888, 24'd8380416, 24'd8380416};
    logic [3:0]  r1t [4] = '{4'd0, 4'd15, 4'd1, 4'd15};
    logic [23:0] ext [4] = '{24'd0, 24'd8118528, 24'd523775, 24'd7856639};
    for (int v = 0; v < 4; v++) begin
      int nw;
      bit seen;
      nw = 0; seen = 1'b0;
      r0v = r0t[v]; r1v = r1t[v];
      start_run(1, 15'h000, 15'h010);
      for (int c = 1; c <= 200 && !seen; c++) begin
        @(negedge clk);
        if (c == 1) recomp_enable = 1'b0;
        if (mem_wr_en) begin
          checks++;
          if (mem_wr_data !== {4{ext[v]}}) begin
            errors++;
            $display("FAIL values[%0d] wr_data got %h want %h", v, mem_wr_data, {4{ext[v]}});
          end
          nw++;
        end
        if (recomp_done) seen = 1'b1;
      end
      checks++;
      if (!seen || nw != 64) begin
        errors++;
        $display("FAIL values[%0d] completion done=%0d writes=%0d want done=1 writes=64", v, seen, nw);
      end
      idle(3);
    end
  endtask

  task automatic test_timing();
    r0v = 24'd5; r1v = 4'd2;
    start_run(2, 15'h100, 15'h400);
    for (int c = 1; c <= 135; c++) begin
      @(negedge clk);
      if (c == 1) recomp_enable = 1'b0;
      obs = {mem_rd_en, mem_rd_addr, r1_rd_addr, mem_wr_en, mem_wr_addr, recomp_busy, recomp_done};
      ev  = exp_vec(c, 2, 15'h100, 15'h400);
      checks++;
      if (obs !== ev) begin
        errors++; $display("FAIL timing c=%0d got %h want %h", c, obs, ev);
      end
    end
  endtask

  task automatic test_zero_poly();
    start_run(0, 15'h050, 15'h060);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) recomp_enable = 1'b0;
      obs = {mem_rd_en, mem_rd_addr, r1_rd_addr, mem_wr_en, mem_wr_addr, recomp_busy, recomp_done};
      ev  = exp_vec(c, 0, 15'h050, 15'h060);
      checks++;
      if (obs !== ev) begin
        errors++; $display("FAIL zero_poly c=%0d got %h want %h", c, obs, ev);
      end
    end
  endtask

  task automatic test_repulse();
    start_run(1, 15'h020, 15'h300);
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      if (c == 1) recomp_enable = 1'b0;
      if (c == 20) begin
        recomp_enable = 1'b1; num_poly = 4'd3; src_base_addr = 15'h555; dest_base_addr = 15'h111;
      end
      if (c == 21) recomp_enable = 1'b0;
      obs = {mem_rd_en, mem_rd_addr, r1_rd_addr, mem_wr_en, mem_wr_addr, recomp_busy, recomp_done};
      ev  = exp_vec(c, 1, 15'h020, 15'h300);
      checks++;
      if (obs !== ev) begin
        errors++; $display("FAIL repulse c=%0d got %h want %h", c, obs, ev);
      end
    end
  endtask

  task automatic test_zeroize();
    start_run(1, 15'h040, 15'h200);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 1) recomp_enable = 1'b0;
      if (c == 30) zeroize = 1'b1;
      if (c == 31) zeroize = 1'b0;
      obs = {mem_rd_en, mem_rd_addr, r1_rd_addr, mem_wr_en, mem_wr_addr, recomp_busy, recomp_done};
      ev  = (c <= 30) ? exp_vec(c, 1, 15'h040, 15'h200) : 47'd0;
      checks++;
      if (obs !== ev) begin
        errors++; $display("FAIL zeroize c=%0d got %h want %h", c, obs, ev);
      end
      if (c == 31) begin
        checks++;
        if (mem_wr_data !== 96'd0) begin
          errors++; $display("FAIL zeroize_wr_data got %h want 0", mem_wr_data);
        end
      end
    end
    // Fresh start after the abort runs normally
    start_run(1, 15'h080, 15'h600);
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (c == 1) recomp_enable = 1'b0;
      obs = {mem_rd_en, mem_rd_addr, r1_rd_addr, mem_wr_en, mem_wr_addr, recomp_busy, recomp_done};
      ev  = exp_vec(c, 1, 15'h080, 15'h600);
      checks++;
      if (obs !== ev) begin
        errors++; $display("FAIL restart c=%0d got %h want %h", c, obs, ev);
      end
    end
  endtask

`ifdef RECOMPOSE_RANGE_CHECK_EN
  task automatic test_range_check();
    logic [23:0] r0t [2] = '{24'd261889, 24'd8118529};
    logic        errt [2] = '{1'b1, 1'b0};
    for (int v = 0; v < 2; v++) begin
      bit seen;
      int nw;
      seen = 1'b0; nw = 0;
      r0v = r0t[v]; r1v = 4'd0;
      start_run(1, 15'h000, 15'h100);
      for (int c = 1; c <= 200 && !seen; c++) begin
        @(negedge clk);
        if (c == 1) recomp_enable = 1'b0;
        if (mem_wr_en) begin
          checks++;
          if (mem_wr_data !== {4{r0t[v]}}) begin
            errors++;
            $display("FAIL range[%0d] wr_data got %h want %h", v, mem_wr_data, {4{r0t[v]}});
          end
          nw++;
        end
        if (recomp_done) seen = 1'b1;
      end
      checks++;
      if (!seen || nw != 64) begin
        errors++;
        $display("FAIL range[%0d] completion done=%0d writes=%0d want done=1 writes=64", v, seen, nw);
      end
      checks++;
      if (recomp_err !== errt[v]) begin
        errors++; $display("FAIL range[%0d] err got %0b want %0b", v, recomp_err, errt[v]);
      end
      idle(5);
      checks++;
      if (recomp_err !== errt[v]) begin
        errors++; $display("FAIL range[%0d] err_sticky got %0b want %0b", v, recomp_err, errt[v]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_values();
    idle(2);
    test_timing();
    idle(2);
    test_zero_poly();
    idle(2);
    test_repulse();
    idle(2);
    test_zeroize();
    idle(2);
`ifdef RECOMPOSE_RANGE_CHECK_EN
    test_range_check();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
